ifetch_prefetcher: RTL

- Instruction-fetch front end that sits directly upstream of the ROM controller and drives its bus request port.
- Issues 4-byte, word-aligned read requests to sequential addresses.
- Captures the returned words, together with their PC and fault flag, into a small prefetch FIFO.
- Presents the FIFO head to the core over a valid/ready handshake. A redirect (jump/trap) flushes the FIFO and restarts fetching.

---
 rtl/ifetch_prefetcher_pkg.sv | 18 +
 rtl/ifetch_prefetcher_if.sv | 32 +++
 rtl/ifetch_fifo.sv | 54 +++++
 rtl/ifetch_prefetcher.sv | 91 +++++++++
 4 files changed

// File: rtl/ifetch_prefetcher_pkg.sv
// Shared prefetcher definitions: bus access-size codes, reset PC default
// and the width of one prefetch FIFO entry {pc, word, fault}.
`ifndef BUS_ACC_DEFS_SVH
`define BUS_ACC_DEFS_SVH
`define BUS_ACC_1B  2'd0
`define BUS_ACC_2B  2'd1
`define BUS_ACC_4B  2'd2
`define BUS_ACC_CNT 3
`endif

package ifetch_prefetcher_pkg;
  localparam int BUS_ACC_W = $clog2(`BUS_ACC_CNT);
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic int fetch_entry_w(input int addr_width);
    return addr_width + 33;
  endfunction
endpackage

// File: rtl/ifetch_prefetcher_if.sv
// Core-side fetch handshake plus ROM bus request/response signals.
// master = prefetcher view, slave = core/ROM-controller view.
interface ifetch_prefetcher_if import ifetch_prefetcher_pkg::*; #(
  parameter int ADDR_WIDTH = 32
);
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_fault;
  logic                  bus_req;
  logic                  bus_resp;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_wr_b;
  logic [BUS_ACC_W-1:0]  bus_acc;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic                  bus_fault;

  modport master (
    input  redirect, redirect_pc, instr_ready, bus_resp, bus_rdata, bus_fault,
    output instr_valid, instr, instr_pc, instr_fault,
           bus_req, bus_addr, bus_wr_b, bus_acc, bus_wdata
  );
  modport slave (
    output redirect, redirect_pc, instr_ready, bus_resp, bus_rdata, bus_fault,
    input  instr_valid, instr, instr_pc, instr_fault,
           bus_req, bus_addr, bus_wr_b, bus_acc, bus_wdata
  );
endinterface

// File: rtl/ifetch_fifo.sv
// Generic sync FIFO with flush; 1-cycle write-to-read latency, read-first on push+pop.
// No internal backpressure: callers consult full/count before pushing.
module ifetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
    !(push && full && !do_pop && !flush));
endmodule

// File: rtl/ifetch_prefetcher.sv
// Sequential instruction prefetcher; 2-cycle startup then 1 word/cycle with a 1-cycle slave.
// Stops issuing when FIFO entries plus the in-flight fetch would exceed FIFO_DEPTH.
module ifetch_prefetcher import ifetch_prefetcher_pkg::*; #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rstn,
  ifetch_prefetcher_if.master io
);
  localparam int EW = fetch_entry_w(ADDR_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] txn_pc;
  logic                  txn_fault;
  logic                  outstanding;
  logic                  discard;
  logic                  pop;
  logic                  issue;
  logic                  resp;
  logic                  take_word;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic [EW-1:0]         fifo_din;
  logic [EW-1:0]         fifo_dout;

  // Occupancy counts the in-flight fetch so its response always has a slot.
  assign pop       = ~fifo_empty & io.instr_ready;
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(outstanding) - (CW+1)'(pop);
  assign issue     = rstn & ~io.redirect & (~outstanding | io.bus_resp)
                   & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign resp      = io.bus_resp & outstanding;
  assign take_word = resp & ~discard & ~io.redirect;
  assign fifo_push = take_word & (~fifo_full | pop);
  assign fifo_pop  = pop & ~io.redirect;
  assign fifo_din  = {txn_pc, io.bus_rdata, txn_fault};

  ifetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (io.redirect),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign io.instr_valid = ~fifo_empty;
  assign {io.instr_pc, io.instr, io.instr_fault} = fifo_dout;
  assign io.bus_req   = issue;
  assign io.bus_addr  = fetch_pc;
  assign io.bus_wr_b  = 1'b0;
  assign io.bus_acc   = `BUS_ACC_4B;
  assign io.bus_wdata = '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      txn_pc      <= '0;
      txn_fault   <= 1'b0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (issue)     outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;

      if (io.redirect) begin
        fetch_pc <= io.redirect_pc & ~ADDR_WIDTH'(3);
        // A fetch still in flight belongs to the old stream; drop it when it lands.
        if (outstanding & ~io.bus_resp) discard <= 1'b1;
        else if (resp)                  discard <= 1'b0;
      end else begin
        if (resp & discard) discard <= 1'b0;
        if (issue) begin
          txn_pc    <= fetch_pc;
          txn_fault <= io.bus_fault;
          fetch_pc  <= fetch_pc + ADDR_WIDTH'(4);
        end
      end
    end
  end
endmodule
